core_pcgen_hs: RTL

Next-generation PC generator for the core fetch stage. It holds the program counter and presents it to instruction memory through a valid/ready request handshake. The PC advances only when a fetch is accepted. The block also provides a post-reset boot delay, redirect priority for software reset and jumps, and a trap state for misaligned jump targets. It sits between the control/hazard unit (reset, jump, hold flags) and the instruction-fetch bus interface.

---
 rtl/core_pcgen_hs.sv | 115 +++++++++++
 1 files changed

// File: rtl/core_pcgen_hs.sv
// Fetch-stage PC generator with valid/ready request handshake, boot delay and misaligned-jump trap.
// Optional compressed-instruction support is enabled by defining RVC_EN.
module core_pcgen_hs #(
  parameter int unsigned           XLEN       = 32,
  parameter logic [XLEN-1:0]       RESET_ADDR = '0,
  parameter int unsigned           BOOT_DELAY = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            reset_flag_i,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            hold_flag_i,
  input  logic            inst_is_c_i,
  input  logic            req_ready_i,
  output logic            req_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] badaddr_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } state_e;

  // BOOT_DELAY of 0 or 1 both leave boot on the first clock after reset.
  localparam logic [3:0] BOOT_LAST = 4'((BOOT_DELAY == 0) ? 0 : BOOT_DELAY - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] badaddr_q, badaddr_d;
  logic            jump_misaligned;
  logic [XLEN-1:0] pc_incr;

`ifdef RVC_EN
  assign jump_misaligned = jump_addr_i[0];
  assign pc_incr         = inst_is_c_i ? XLEN'(2) : XLEN'(4);
`else
  logic unused_inst_is_c;
  assign unused_inst_is_c = inst_is_c_i;
  assign jump_misaligned  = |jump_addr_i[1:0];
  assign pc_incr          = XLEN'(4);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_BOOT;
      cnt_q      <= '0;
      pc_q       <= RESET_ADDR;
      misalign_q <= 1'b0;
      badaddr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      badaddr_q  <= badaddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    badaddr_d   = badaddr_q;
    req_valid_o = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        if (reset_flag_i) begin
          cnt_d = '0;
          pc_d  = RESET_ADDR;
        end else if (cnt_q == BOOT_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RUN, S_TRAP: begin
        req_valid_o = (state_q == S_RUN) && !hold_flag_i;
        if (reset_flag_i) begin
          state_d    = S_BOOT;
          cnt_d      = '0;
          pc_d       = RESET_ADDR;
          misalign_d = 1'b0;
        end else if (jump_flag_i && !jump_misaligned) begin
          state_d    = S_RUN;
          pc_d       = jump_addr_i;
          misalign_d = 1'b0;
        end else if (jump_flag_i) begin
          state_d    = S_TRAP;
          badaddr_d  = jump_addr_i;
          misalign_d = 1'b1;
        end else if (req_valid_o && req_ready_i) begin
          pc_d = pc_q + pc_incr;
        end
      end
      default: begin
        state_d = S_BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;
  assign badaddr_o  = badaddr_q;

endmodule
